// File: rtl/nav_pkg.sv
// ============================================================================
//  Module   : nav_pkg
//  Brief    : Shared encodings for the navigation system (phases, commands,
//             mission states, color and size codes).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nav_pkg;

  localparam logic [1:0] RUN_INI = 2'b00;
  localparam logic [1:0] RUN_EXC = 2'b01;
  localparam logic [1:0] RUN_COM = 2'b10;
  localparam logic [1:0] RUN_ERR = 2'b11;

  localparam logic [4:0] NO_COMMAND = 5'b01100;
  localparam logic [4:0] TURN_RIGHT = 5'b01100;
  localparam logic [4:0] TURN_LEFT  = 5'b00110;
  localparam logic [4:0] STRAIGHT   = 5'b01110;

  localparam logic [4:0] START       = 5'd0;
  localparam logic [4:0] INI_FORWARD = 5'd1;
  localparam logic [4:0] INI_LEFT    = 5'd2;
  localparam logic [4:0] SEA_SCAN    = 5'd3;
  localparam logic [4:0] RIGHT_CARGO = 5'd4;
  localparam logic [4:0] CARGO_SCAN  = 5'd5;

  localparam logic [1:0] COLOR_NONE  = 2'b00;
  localparam logic [1:0] COLOR_RED   = 2'b01;
  localparam logic [1:0] COLOR_GREEN = 2'b10;
  localparam logic [1:0] COLOR_BLUE  = 2'b11;

  localparam logic [1:0] SIZE_NONE   = 2'b00;
  localparam logic [1:0] SIZE_SMALL  = 2'b01;
  localparam logic [1:0] SIZE_MEDIUM = 2'b10;
  localparam logic [1:0] SIZE_LARGE  = 2'b11;

  localparam logic [7:0] FORWARD_MARGIN = 8'd5;
  localparam logic [7:0] SEA_PATH       = 8'd4;
  localparam logic [7:0] CARGO_PATH     = 8'd16;
  localparam logic [7:0] SCAN_COMPARE   = 8'd12;

  // The mission loops RIGHT_CARGO <-> CARGO_SCAN forever after the opening steps.
  function automatic logic [4:0] next_state(input logic [4:0] s);
    case (s)
      INI_FORWARD: next_state = INI_LEFT;
      INI_LEFT:    next_state = SEA_SCAN;
      SEA_SCAN:    next_state = RIGHT_CARGO;
      RIGHT_CARGO: next_state = CARGO_SCAN;
      CARGO_SCAN:  next_state = RIGHT_CARGO;
      default:     next_state = START;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/nav_mission_sequencer.sv
// ============================================================================
//  Module   : nav_mission_sequencer
//  Brief    : Walks the fixed mission step list and drives the
//             COMMAND / PATH / COMPARE_DISTANCE / RUN_FLAG handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nav_mission_sequencer
  import nav_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START_HOLD,
  input  logic       NEXT_FLAG,
  input  logic [7:0] DISTANCE_SIDE_FRONT,
  input  logic [7:0] DISTANCE_FRONT,
  input  logic [7:0] RIGHT_DISTANCE,
  output logic [4:0] COMMAND,
  output logic [7:0] PATH,
  output logic [7:0] COMPARE_DISTANCE,
  output logic [1:0] RUN_FLAG,
  output logic [4:0] STATE,
  output logic [7:0] INITIAL_X,
  output logic [7:0] INITIAL_Y
);

  logic [4:0] r_state;
  logic [1:0] r_run_flag;
  logic [4:0] r_command;
  logic [7:0] r_path;
  logic [7:0] r_compare;
  logic [7:0] r_initial_x;
  logic [7:0] r_initial_y;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= START;
      r_run_flag  <= RUN_INI;
      r_command   <= NO_COMMAND;
      r_path      <= 8'd0;
      r_compare   <= 8'd0;
      r_initial_x <= 8'd0;
      r_initial_y <= 8'd0;
    end else if (r_run_flag == RUN_ERR) begin
      // Error phase freezes everything until an external reset.
      r_state <= r_state;
    end else begin
      case (r_state)
        START: begin
          if (START_HOLD) begin
            r_initial_x <= DISTANCE_SIDE_FRONT;
            r_initial_y <= DISTANCE_FRONT;
          end else begin
            r_state <= INI_FORWARD;
          end
        end
        INI_FORWARD, INI_LEFT, SEA_SCAN, RIGHT_CARGO, CARGO_SCAN: begin
          case (r_run_flag)
            RUN_INI: begin
              r_run_flag <= RUN_EXC;
              case (r_state)
                INI_FORWARD: begin
                  r_command <= STRAIGHT;
                  r_path    <= DISTANCE_SIDE_FRONT;
                  r_compare <= DISTANCE_SIDE_FRONT - FORWARD_MARGIN;
                end
                INI_LEFT: begin
                  r_command <= TURN_LEFT;
                  r_compare <= DISTANCE_SIDE_FRONT;
                end
                SEA_SCAN: begin
                  r_command <= STRAIGHT;
                  r_path    <= SEA_PATH;
                  r_compare <= SCAN_COMPARE;
                end
                RIGHT_CARGO: begin
                  r_command <= TURN_RIGHT;
                  r_compare <= RIGHT_DISTANCE;
                end
                default: begin
                  r_command <= STRAIGHT;
                  r_path    <= CARGO_PATH;
                  r_compare <= SCAN_COMPARE;
                end
              endcase
            end
            RUN_EXC: begin
              if (NEXT_FLAG) r_run_flag <= RUN_COM;
            end
            default: begin
              r_run_flag <= RUN_INI;
              r_state    <= next_state(r_state);
            end
          endcase
        end
        default: begin
          r_state    <= START;
          r_run_flag <= RUN_INI;
        end
      endcase
    end
  end

  assign COMMAND          = r_command;
  assign PATH             = r_path;
  assign COMPARE_DISTANCE = r_compare;
  assign RUN_FLAG         = r_run_flag;
  assign STATE            = r_state;
  assign INITIAL_X        = r_initial_x;
  assign INITIAL_Y        = r_initial_y;

endmodule

`default_nettype wire

// File: tb/tb_nav_mission_sequencer.sv
// ============================================================================
//  Module   : tb_nav_mission_sequencer
//  Brief    : Self-checking bench: directed mission walk plus randomized
//             stimulus against a step-list reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nav_mission_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START_HOLD = 1'b1;
  logic       NEXT_FLAG = 1'b0;
  logic [7:0] DISTANCE_SIDE_FRONT = 8'd0;
  logic [7:0] DISTANCE_FRONT = 8'd0;
  logic [7:0] RIGHT_DISTANCE = 8'd0;
  logic [4:0] COMMAND;
  logic [7:0] PATH;
  logic [7:0] COMPARE_DISTANCE;
  logic [1:0] RUN_FLAG;
  logic [4:0] STATE;
  logic [7:0] INITIAL_X;
  logic [7:0] INITIAL_Y;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mission progress as a step index plus a 0/1/2 phase counter.
  bit         m_started;
  int         m_step;
  int         m_phase;
  logic [4:0] m_cmd;
  logic [7:0] m_path, m_cmp, m_ix, m_iy;

  always #5 CLK = ~CLK;

  nav_mission_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START_HOLD(START_HOLD), .NEXT_FLAG(NEXT_FLAG),
    .DISTANCE_SIDE_FRONT(DISTANCE_SIDE_FRONT), .DISTANCE_FRONT(DISTANCE_FRONT),
    .RIGHT_DISTANCE(RIGHT_DISTANCE), .COMMAND(COMMAND), .PATH(PATH),
    .COMPARE_DISTANCE(COMPARE_DISTANCE), .RUN_FLAG(RUN_FLAG), .STATE(STATE),
    .INITIAL_X(INITIAL_X), .INITIAL_Y(INITIAL_Y)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Steps 0,1,2 are the opening moves; afterwards they alternate turn (4) / scan (5).
  function automatic int state_of(input int n);
    if (n < 3) return n + 1;
    return 4 + ((n - 3) % 2);
  endfunction

  task automatic model_edge(input bit rst, input bit hold, input bit nf,
                            input logic [7:0] dsf, input logic [7:0] df, input logic [7:0] rd);
    if (rst) begin
      m_started = 0; m_step = 0; m_phase = 0;
      m_cmd = 5'b01100; m_path = 0; m_cmp = 0; m_ix = 0; m_iy = 0;
    end else if (!m_started) begin
      if (hold) begin m_ix = dsf; m_iy = df; end
      else begin m_started = 1; m_step = 0; m_phase = 0; end
    end else if (m_phase == 0) begin
      case (state_of(m_step))
        1: begin m_cmd = 5'b01110; m_path = dsf; m_cmp = dsf - 8'd5; end
        2: begin m_cmd = 5'b00110; m_cmp = dsf; end
        3: begin m_cmd = 5'b01110; m_path = 8'd4; m_cmp = 8'd12; end
        4: begin m_cmd = 5'b01100; m_cmp = rd; end
        default: begin m_cmd = 5'b01110; m_path = 8'd16; m_cmp = 8'd12; end
      endcase
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (nf) m_phase = 2;
    end else begin
      m_phase = 0;
      m_step++;
    end
  endtask

  task automatic step(input bit rst, input bit hold, input bit nf,
                      input logic [7:0] dsf, input logic [7:0] df, input logic [7:0] rd);
    RESET = rst; START_HOLD = hold; NEXT_FLAG = nf;
    DISTANCE_SIDE_FRONT = dsf; DISTANCE_FRONT = df; RIGHT_DISTANCE = rd;
    @(posedge CLK);
    model_edge(rst, hold, nf, dsf, df, rd);
    #1;
    chk("STATE", STATE, m_started ? state_of(m_step) : 0);
    chk("RUN_FLAG", RUN_FLAG, m_phase);
    chk("COMMAND", COMMAND, m_cmd);
    chk("PATH", PATH, m_path);
    chk("COMPARE", COMPARE_DISTANCE, m_cmp);
    chk("INITIAL_X", INITIAL_X, m_ix);
    chk("INITIAL_Y", INITIAL_Y, m_iy);
  endtask

  initial begin
    m_started = 0; m_step = 0; m_phase = 0;
    m_cmd = 5'b01100; m_path = 0; m_cmp = 0; m_ix = 0; m_iy = 0;

    step(1, 1, 0, 8'd0, 8'd0, 8'd55);
    step(1, 1, 0, 8'd0, 8'd0, 8'd55);
    chk("reset_cmd", COMMAND, 5'b01100);
    step(0, 1, 0, 8'd40, 8'd90, 8'd55);
    step(0, 1, 0, 8'd40, 8'd90, 8'd55);
    chk("init_x", INITIAL_X, 8'd40);
    chk("init_y", INITIAL_Y, 8'd90);
    chk("start_hold_state", STATE, 5'd0);

    step(0, 0, 0, 8'd30, 8'd90, 8'd55);
    chk("start_exit", STATE, 5'd1);
    step(0, 0, 0, 8'd30, 8'd90, 8'd55);
    chk("fwd_path", PATH, 8'd30);
    chk("fwd_cmp", COMPARE_DISTANCE, 8'd25);
    step(0, 0, 0, 8'd30, 8'd90, 8'd55);
    step(0, 0, 0, 8'd30, 8'd90, 8'd55);
    chk("exc_held", RUN_FLAG, 2'b01);

    step(0, 0, 1, 8'd22, 8'd90, 8'd55);
    chk("com_flag", RUN_FLAG, 2'b10);
    step(0, 0, 0, 8'd22, 8'd90, 8'd55);
    chk("left_state", STATE, 5'd2);
    step(0, 0, 0, 8'd22, 8'd90, 8'd55);
    chk("left_cmd", COMMAND, 5'b00110);
    chk("left_cmp", COMPARE_DISTANCE, 8'd22);
    chk("left_path_kept", PATH, 8'd30);

    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'd22, 8'd90, 8'd55);

    // Forward step with DSF below the margin must wrap.
    step(1, 0, 0, 8'd3, 8'd0, 8'd55);
    step(0, 0, 0, 8'd3, 8'd0, 8'd55);
    step(0, 0, 0, 8'd3, 8'd0, 8'd55);
    chk("wrap_cmp", COMPARE_DISTANCE, 8'd254);

    // Walk into CARGO_SCAN EXC then reset.
    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'd3, 8'd0, 8'd55);
    while (!(STATE == 5'd5 && RUN_FLAG == 2'b01) && n_checks < 100000)
      step(0, 0, (m_phase == 1 && state_of(m_step) == 5) ? 1'b0 : 1'b1, 8'd3, 8'd0, 8'd55);
    chk("in_cargo_exc", STATE, 5'd5);
    step(1, 0, 0, 8'd3, 8'd0, 8'd55);
    chk("rst_state", STATE, 5'd0);
    chk("rst_path", PATH, 8'd0);

    for (int i = 0; i < 3000; i++)
      step(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
           8'($urandom), 8'($urandom), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nav_mission_sequencer.md
# nav_mission_sequencer

Top-level mission sequencer for the navigation system. It walks a fixed list of motion steps: initial forward run, left turn, sea-zone scan, then an endless loop of right turn and cargo scan. For each step it drives a motion command, a path distance and a compare distance to the Navigation block, and it advances when Navigation raises NEXT_FLAG. It sits beside Navigation, localization and Arm in the system top and owns the COMMAND / PATH / COMPARE_DISTANCE / RUN_FLAG handshake.

## Interface
No parameters; all encodings are package constants.
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- START_HOLD  in  1  switch SW[7]; 1 = hold in START and sample initial position, 0 = begin mission
- NEXT_FLAG  in  1  Navigation reports the current step is complete
- DISTANCE_SIDE_FRONT  in  8  left-front ultrasonic distance
- DISTANCE_FRONT  in  8  front ultrasonic distance
- RIGHT_DISTANCE  in  8  right-side distance estimate from localization
- COMMAND  out  5  motion command to Navigation
- PATH  out  8  wall distance to hold during a straight move
- COMPARE_DISTANCE  out  8  distance at which the step ends
- RUN_FLAG  out  2  step phase, shared with Navigation
- STATE  out  5  current mission state, for debug and display
- INITIAL_X, INITIAL_Y  out  8 each  initial position latched in START

## Operation
- Encodings:
  - RUN_INI=00, RUN_EXC=01, RUN_COM=10, RUN_ERR=11.
  - NO_COMMAND=TURN_RIGHT=01100, TURN_LEFT=00110, STRAIGHT=01110.
  - States: START=0, INI_FORWARD=1, INI_LEFT=2, SEA_SCAN=3, RIGHT_CARGO=4, CARGO_SCAN=5.
- Reset values: STATE=START, RUN_FLAG=RUN_INI, COMMAND=NO_COMMAND, PATH=0, COMPARE_DISTANCE=0, INITIAL_X=0, INITIAL_Y=0.
- START:
  - START_HOLD=1: every cycle, INITIAL_X<=DISTANCE_SIDE_FRONT and INITIAL_Y<=DISTANCE_FRONT.
  - START_HOLD=0: STATE<=INI_FORWARD and INITIAL_X/Y hold their values.
- Every motion state uses the same three phases:
  - RUN_INI: load the step outputs, then RUN_FLAG<=RUN_EXC.
  - RUN_EXC: RUN_FLAG<=RUN_COM when NEXT_FLAG=1; otherwise stay in RUN_EXC.
  - RUN_COM: RUN_FLAG<=RUN_INI and STATE<=successor.
- Step loads (registers not listed keep their value):
  - INI_FORWARD: COMMAND=STRAIGHT, PATH=DSF, COMPARE=DSF-5 (8-bit modular, so DSF<5 wraps). Successor INI_LEFT.
  - INI_LEFT: COMMAND=TURN_LEFT, COMPARE=DSF. Successor SEA_SCAN.
  - SEA_SCAN: COMMAND=STRAIGHT, PATH=4, COMPARE=12. Successor RIGHT_CARGO.
  - RIGHT_CARGO: COMMAND=TURN_RIGHT, COMPARE=RIGHT_DISTANCE. Successor CARGO_SCAN.
  - CARGO_SCAN: COMMAND=STRAIGHT, PATH=16, COMPARE=12. Successor RIGHT_CARGO (loops forever).
- Input sampling:
  - NEXT_FLAG is ignored outside RUN_EXC.
  - START_HOLD is ignored outside START.
  - Distances are sampled only in RUN_INI of the step that uses them (and in START for INITIAL_X/Y).
- RUN_ERR is never entered by normal flow. If RUN_FLAG=RUN_ERR, all registers hold until reset.
- An illegal STATE (6..31) sets STATE<=START and RUN_FLAG<=RUN_INI on the next edge.

## Timing
- START exit: START_HOLD sampled 0 at edge k → STATE=INI_FORWARD after edge k.
- Step outputs are valid one edge after RUN_INI is entered, in the same cycle RUN_FLAG becomes RUN_EXC.
- Minimum step length is 3 cycles (INI, EXC, COM), when NEXT_FLAG is already 1 in the first EXC cycle.
- Next-step latency: NEXT_FLAG sampled 1 at edge n → RUN_COM after n, new STATE and RUN_INI after n+1, new COMMAND/PATH/COMPARE and RUN_EXC after n+2.
- A NEXT_FLAG held high across steps advances one step per 3 cycles; no edge detection.
- RESET has priority over all logic. Reset asserted mid-step returns every output to its reset value on the next edge.

## Structure
- Shared package nav_pkg holds:
  - RUN_* phase codes
  - command codes
  - mission state codes
  - color and size codes used by the system
- Single module, no sub-module required: one always block for the FSM and output registers.

## Test plan
- Reset, then START_HOLD=1 with DSF=40, DF=90 → INITIAL_X=40, INITIAL_Y=90; STATE stays 0; COMMAND=01100.
- START_HOLD→0, DSF=30, NEXT_FLAG=0 → STATE=1, then COMMAND=01110, PATH=30, COMPARE=25, RUN_FLAG=01 held.
- Pulse NEXT_FLAG one cycle in EXC, DSF=22 → RUN_FLAG 10 then 00; STATE=2; COMMAND=00110, COMPARE=22, PATH stays 30.
- NEXT_FLAG tied 1 → SEA_SCAN (PATH=4, COMPARE=12), then RIGHT_CARGO (COMPARE=RIGHT_DISTANCE=55), then CARGO_SCAN (PATH=16), then back to RIGHT_CARGO; 3 cycles per step.
- INI_FORWARD with DSF=3 → COMPARE_DISTANCE=254 (wrap).
- Assert RESET during CARGO_SCAN RUN_EXC → next edge all outputs at reset values; STATE=START.
